// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each port gets a one-entry response slot; illegal or misaligned requests are answered with err and never reach memory.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid_i,
  output logic                  p0_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata_i,
  input  logic                  p0_req_we_i,
  input  logic [1:0]            p0_req_size_i,
  output logic                  p0_rsp_valid_o,
  input  logic                  p0_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata_o,
  output logic                  p0_rsp_err_o,
  input  logic                  p1_req_valid_i,
  output logic                  p1_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata_i,
  input  logic                  p1_req_we_i,
  input  logic [1:0]            p1_req_size_i,
  output logic                  p1_rsp_valid_o,
  input  logic                  p1_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata_o,
  output logic                  p1_rsp_err_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  MemWrite_o,
  output logic                  MemRead_o,
  output logic [1:0]            size_o,
  input  logic [DATA_WIDTH-1:0] data_read_i
);

  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0]            rsp_ready;
  logic [1:0]            eligible;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [1:0]            req_size  [2];

  logic                  full_reg  [2];
  logic                  err_reg   [2];
  logic [DATA_WIDTH-1:0] rdata_reg [2];
  logic                  last_grant_reg;

  logic                  win;
  logic                  any_grant;
  logic                  win_we;
  logic                  win_legal;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [1:0]            win_size;

  assign req_valid    = {p1_req_valid_i, p0_req_valid_i};
  assign req_we       = {p1_req_we_i, p0_req_we_i};
  assign rsp_ready    = {p1_rsp_ready_i, p0_rsp_ready_i};
  assign req_addr[0]  = p0_req_addr_i;
  assign req_addr[1]  = p1_req_addr_i;
  assign req_wdata[0] = p0_req_wdata_i;
  assign req_wdata[1] = p1_req_wdata_i;
  assign req_size[0]  = p0_req_size_i;
  assign req_size[1]  = p1_req_size_i;

  // Only eligible ports compete, so a blocked port never burns the round-robin turn.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (eligible == 2'b11) grant = last_grant_reg ? 2'b01 : 2'b10;
      else                   grant = eligible;
    end
  end

  assign win       = grant[1];
  assign any_grant = |grant;
  assign win_we    = req_we[win];
  assign win_addr  = req_addr[win];
  assign win_wdata = req_wdata[win];
  assign win_size  = req_size[win];

  always_comb begin
    win_legal = 1'b0;
    case (win_size)
      2'b00:   win_legal = 1'b1;
      2'b01:   win_legal = !win_addr[0];
      2'b10:   win_legal = (win_addr[1:0] == 2'b00);
      default: win_legal = 1'b0;
    endcase
  end

  assign address_o    = any_grant ? win_addr  : '0;
  assign write_data_o = any_grant ? win_wdata : '0;
  assign size_o       = any_grant ? win_size  : 2'b00;
  assign MemWrite_o   = any_grant && win_legal && win_we;
  assign MemRead_o    = any_grant && win_legal && !win_we;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // A full slot can still accept when it is being drained this same cycle.
      assign eligible[gi] = req_valid[gi] && (!full_reg[gi] || rsp_ready[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          full_reg[gi]  <= 1'b0;
          err_reg[gi]   <= 1'b0;
          rdata_reg[gi] <= '0;
        end else if (grant[gi]) begin
          full_reg[gi]  <= 1'b1;
          err_reg[gi]   <= !win_legal;
          rdata_reg[gi] <= (win_legal && !win_we) ? data_read_i : '0;
        end else if (rsp_ready[gi]) begin
          full_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)            last_grant_reg <= 1'b1;
    else if (any_grant) last_grant_reg <= win;
  end

  assign p0_req_ready_o = grant[0];
  assign p1_req_ready_o = grant[1];
  assign p0_rsp_valid_o = full_reg[0];
  assign p1_rsp_valid_o = full_reg[1];
  assign p0_rsp_rdata_o = rdata_reg[0];
  assign p1_rsp_rdata_o = rdata_reg[1];
  assign p0_rsp_err_o   = err_reg[0];
  assign p1_rsp_err_o   = err_reg[1];

endmodule
